// File: rtl/ram_load_unit_if.sv
// Request/response bundle between the load unit and its neighbours.
// The master side presents load requests and consumes results. The slave side is the load unit.
`timescale 1ns/1ps

interface ram_load_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        Lb;
    logic        Lh;
    logic        Lu;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] load_data;
    logic        addr_err;

    modport master (
        output req_valid, req_addr, Lb, Lh, Lu, rsp_ready,
        input  req_ready, rsp_valid, load_data, addr_err
    );

    modport slave (
        input  req_valid, req_addr, Lb, Lh, Lu, rsp_ready,
        output req_ready, rsp_valid, load_data, addr_err
    );
endinterface

// File: rtl/ram_load_unit.sv
// Load unit: takes one byte/half/word load at a time and reads the word from a synchronous RAM.
// It then returns the aligned, sign- or zero-extended result.
// Misaligned half/word loads skip the RAM and answer with addr_err.
// Every response passes through one ALIGN cycle before rsp_valid rises.
// So a good load responds RAM_LATENCY+2 edges after accept, and a misaligned load responds 1 edge after accept.
`timescale 1ns/1ps

module ram_load_unit #(
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_load_unit_if.slave       bus,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_re,
    input  logic [DATA_BITS-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        ALIGN,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        KIND_WORD,
        KIND_BYTE,
        KIND_HALF
    } kind_t;

    state_t         state;
    kind_t          kind;
    kind_t          req_kind;
    logic [1:0]     off;
    logic           zext;
    logic           err_pending;
    logic [2:0]     counter;
    logic [31:0]    raw_data;
    logic [31:0]    aligned;
    logic [31:0]    byte_shift;
    logic [31:0]    half_shift;
    logic           req_misaligned;
    logic [31:0]    word_addr;

    // A request is accepted in IDLE. Ready drops with reset so nothing is taken while rst_n is low.
    assign bus.req_ready = rst_n && (state == IDLE);

    // Decode the incoming request's access type and check its alignment.
    always_comb begin
        req_kind = KIND_WORD;
        if (bus.Lb && !bus.Lh) begin
            req_kind = KIND_BYTE;
        end else if (!bus.Lb && bus.Lh) begin
            req_kind = KIND_HALF;
        end
        req_misaligned = 1'b0;
        if (req_kind == KIND_HALF) begin
            req_misaligned = bus.req_addr[0];
        end else if (req_kind == KIND_WORD) begin
            req_misaligned = (bus.req_addr[1:0] != 2'b00);
        end
        word_addr = {2'b00, bus.req_addr[31:2]};
    end

    // Pick the addressed lane out of the captured RAM word and extend it to 32 bits.
    always_comb begin
        byte_shift = raw_data[31:0] >> {off, 3'b000};
        half_shift = raw_data[31:0] >> {off[1], 4'b0000};
        aligned    = raw_data[31:0];
        if (kind == KIND_BYTE) begin
            aligned = zext ? {24'h000000, byte_shift[7:0]}
                           : {{24{byte_shift[7]}}, byte_shift[7:0]};
        end else if (kind == KIND_HALF) begin
            aligned = zext ? {16'h0000, half_shift[15:0]}
                           : {{16{half_shift[15]}}, half_shift[15:0]};
        end
    end

    // Sequence each load: accept, one-cycle RAM strobe, latency wait, capture, align, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            kind          <= KIND_WORD;
            off           <= 2'b00;
            zext          <= 1'b0;
            err_pending   <= 1'b0;
            counter       <= 3'd0;
            raw_data      <= '0;
            ram_addr      <= '0;
            ram_re        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.load_data <= 32'h0;
            bus.addr_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off  <= bus.req_addr[1:0];
                        kind <= req_kind;
                        zext <= bus.Lu;
                        if (req_misaligned) begin
                            err_pending <= 1'b1;
                            state       <= ALIGN;
                        end else begin
                            err_pending <= 1'b0;
                            ram_addr    <= ADDR_BITS'(word_addr);
                            ram_re      <= 1'b1;
                            state       <= READ;
                        end
                    end
                end
                READ: begin
                    ram_re  <= 1'b0;
                    counter <= 3'(RAM_LATENCY - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (counter == 3'd0) begin
                        raw_data <= ram_dout;
                        state    <= ALIGN;
                    end else begin
                        counter <= counter - 3'd1;
                    end
                end
                ALIGN: begin
                    bus.rsp_valid <= 1'b1;
                    if (err_pending) begin
                        bus.load_data <= 32'h0;
                        bus.addr_err  <= 1'b1;
                    end else begin
                        bus.load_data <= aligned;
                        bus.addr_err  <= 1'b0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_load_unit.sv
// Bench for ram_load_unit.
// It runs two instances, one with RAM latency 3 (index 0) and one with latency 1 (index 1).
// Each instance has its own RAM model. The model puts junk on ram_dout before and after the valid window.
`timescale 1ns/1ps

module tb_ram_load_unit;

    logic        clk;
    logic        rst_n;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  lb_in;
    logic [1:0]  lh_in;
    logic [1:0]  lu_in;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  addr_err;
    logic [1:0]  ram_re;
    logic [31:0] req_addr  [2];
    logic [31:0] load_data [2];
    logic [31:0] ram_addr  [2];

    logic [31:0] mem [256];

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instantiate both latency variants along with their RAM models.
    for (genvar g = 0; g < 2; g++) begin : dut_gen
        localparam int LAT = (g == 0) ? 3 : 1;
        localparam int VI  = (LAT > 1) ? LAT - 2 : 0;

        ram_load_unit_if bus ();
        logic        re_g;
        logic [31:0] addr_g;
        logic [31:0] dout_g;
        logic [7:0]  va;
        logic [31:0] aa [8];

        ram_load_unit #(
            .ADDR_BITS  (32),
            .DATA_BITS  (32),
            .RAM_LATENCY(LAT)
        ) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .bus     (bus.slave),
            .ram_addr(addr_g),
            .ram_re  (re_g),
            .ram_dout(dout_g)
        );

        assign bus.req_valid = req_valid[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.Lb        = lb_in[g];
        assign bus.Lh        = lh_in[g];
        assign bus.Lu        = lu_in[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign load_data[g]  = bus.load_data;
        assign addr_err[g]   = bus.addr_err;
        assign ram_re[g]     = re_g;
        assign ram_addr[g]   = addr_g;

        // The synchronous RAM returns data LAT edges after the strobe cycle and holds it.
        // Outside that window ram_dout carries random junk.
        always @(posedge clk) begin
            if (!rst_n) begin
                va <= 8'h00;
            end else begin
                va <= {va[6:0], re_g};
            end
            for (int i = 7; i > 0; i--) begin
                aa[i] <= aa[i-1];
            end
            aa[0] <= addr_g;
            if (LAT == 1) begin
                if (re_g) dout_g <= mem[addr_g[7:0]];
            end else begin
                if (re_g) dout_g <= $urandom;
                if (va[VI]) dout_g <= mem[aa[VI][7:0]];
            end
            if (va[LAT]) dout_g <= $urandom;
        end
    end

    // Compare one observation against its expected value and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference load semantics: little-endian lane select, then extension by plain arithmetic.
    task automatic modelLoad(input logic [31:0] addr, input logic lbv, input logic lhv, input logic luv,
                             input logic [31:0] word, output logic err, output logic [31:0] data);
        logic is_byte;
        logic is_half;
        int unsigned v;
        is_byte = lbv && !lhv;
        is_half = !lbv && lhv;
        err  = 1'b0;
        data = 32'h0;
        if (is_byte) begin
            v = (word >> (8 * (addr % 4))) % 256;
            data = (!luv && v >= 128) ? v - 32'd256 : v;
        end else if (is_half) begin
            if (addr % 2 != 0) err = 1'b1;
            v = (word >> (16 * ((addr / 2) % 2))) % 65536;
            data = (!luv && v >= 32768) ? v - 32'h10000 : v;
        end else begin
            if (addr % 4 != 0) err = 1'b1;
            data = word;
        end
        if (err) data = 32'h0;
    endtask

    // Present a request and return just after its accept edge.
    task automatic startReq(input int sel, input logic [31:0] addr, input logic lbv, input logic lhv, input logic luv);
        int tries;
        req_valid[sel] = 1'b1;
        req_addr[sel]  = addr;
        lb_in[sel]     = lbv;
        lh_in[sel]     = lhv;
        lu_in[sel]     = luv;
        tries = 0;
        while (req_ready[sel] !== 1'b1 && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        checkOutput("acceptInTime", 32'(tries < 20), 32'd1);
        @(posedge clk); #1;
        req_valid[sel] = 1'b0;
        req_addr[sel]  = $urandom;
        lb_in[sel]     = 1'($urandom);
        lh_in[sel]     = 1'($urandom);
        lu_in[sel]     = 1'($urandom);
    endtask

    // Run one full load. The bench checks strobe timing, response latency, data and error.
    // It then applies 'hold' cycles of backpressure and completes the handshake.
    task automatic applyStimulus(input int sel, input logic [31:0] addr, input logic lbv, input logic lhv,
                                 input logic luv, input int hold, output logic [31:0] got_data, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_data;
        int          k;
        int          re_count;
        int          re_k;
        int          lat;
        bit          done;
        lat = (sel == 0) ? 3 : 1;
        modelLoad(addr, lbv, lhv, luv, mem[addr[9:2]], exp_err, exp_data);
        startReq(sel, addr, lbv, lhv, luv);
        if (!exp_err) checkOutput("ramAddr", ram_addr[sel], addr >> 2);
        k = 0;
        re_count = 0;
        re_k = -1;
        done = 1'b0;
        while (!done && k < 40) begin
            if (ram_re[sel] === 1'b1) begin
                if (re_count == 0) re_k = k;
                re_count++;
            end
            if (rsp_valid[sel] === 1'b1) begin
                done = 1'b1;
            end else begin
                rsp_ready[sel] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                k++;
            end
        end
        rsp_ready[sel] = 1'b0;
        checkOutput("rspLatency", k, exp_err ? 32'd1 : 32'(lat + 2));
        checkOutput("ramReCount", re_count, exp_err ? 32'd0 : 32'd1);
        if (!exp_err) checkOutput("ramReCycle", re_k, 32'd0);
        checkOutput("loadData", load_data[sel], exp_data);
        checkOutput("addrErr", 32'(addr_err[sel]), 32'(exp_err));
        checkOutput("reqReadyBusy", 32'(req_ready[sel]), 32'd0);
        got_data = load_data[sel];
        got_err  = addr_err[sel];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput("holdValid", 32'(rsp_valid[sel]), 32'd1);
            checkOutput("holdData", load_data[sel], exp_data);
            checkOutput("holdReady", 32'(req_ready[sel]), 32'd0);
        end
        rsp_ready[sel] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[sel] = 1'b0;
        checkOutput("doneValid", 32'(rsp_valid[sel]), 32'd0);
        checkOutput("doneReady", 32'(req_ready[sel]), 32'd1);
    endtask

    // Run the directed test-plan items, a mid-access reset, and random loads on both latencies.
    initial begin
        logic [31:0] d;
        logic        e;
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        lb_in     = 2'b00;
        lh_in     = 2'b00;
        lu_in     = 2'b00;
        req_addr[0] = 32'h0;
        req_addr[1] = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h40] = 32'h8A7FC301;

        #2;
        checkOutput("rstReqReady", 32'(req_ready[0]), 32'd0);
        checkOutput("rstRspValid", 32'(rsp_valid[0]), 32'd0);
        checkOutput("rstRamRe", 32'(ram_re[0]), 32'd0);
        checkOutput("rstRamAddr", ram_addr[0], 32'h0);
        checkOutput("rstLoadData", load_data[0], 32'h0);
        checkOutput("rstAddrErr", 32'(addr_err[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("relReqReady0", 32'(req_ready[0]), 32'd1);
        checkOutput("relReqReady1", 32'(req_ready[1]), 32'd1);

        for (int s = 0; s < 2; s++) begin
            applyStimulus(s, 32'h101, 1'b1, 1'b0, 1'b0, 0, d, e);
            checkOutput("tpLB", d, 32'hFFFFFFC3);
            applyStimulus(s, 32'h103, 1'b1, 1'b0, 1'b1, 1, d, e);
            checkOutput("tpLBU", d, 32'h0000008A);
            applyStimulus(s, 32'h102, 1'b0, 1'b1, 1'b0, 0, d, e);
            checkOutput("tpLH", d, 32'hFFFF8A7F);
            applyStimulus(s, 32'h100, 1'b0, 1'b1, 1'b1, 2, d, e);
            checkOutput("tpLHU", d, 32'h0000C301);
            applyStimulus(s, 32'h100, 1'b0, 1'b0, 1'b0, 3, d, e);
            checkOutput("tpLW", d, 32'h8A7FC301);
            checkOutput("tpLWerr", 32'(e), 32'd0);
            applyStimulus(s, 32'h101, 1'b0, 1'b1, 1'b0, 3, d, e);
            checkOutput("tpMisLH", 32'(e), 32'd1);
            applyStimulus(s, 32'h102, 1'b1, 1'b1, 1'b0, 0, d, e);
            checkOutput("tpMisLW", 32'(e), 32'd1);
            checkOutput("tpMisLWdata", d, 32'h0);
        end

        startReq(0, 32'h100, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abortRamRe", 32'(ram_re[0]), 32'd0);
        checkOutput("abortRspValid", 32'(rsp_valid[0]), 32'd0);
        checkOutput("abortLoadData", load_data[0], 32'h0);
        checkOutput("abortAddrErr", 32'(addr_err[0]), 32'd0);
        checkOutput("abortRamAddr", ram_addr[0], 32'h0);
        checkOutput("abortReqReady", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("abortNoRsp", 32'(rsp_valid[0]), 32'd0);
        end
        applyStimulus(0, 32'h100, 1'b0, 1'b0, 1'b0, 1, d, e);
        checkOutput("abortThenLW", d, 32'h8A7FC301);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(n % 2, $urandom_range(0, 1023), 1'($urandom), 1'($urandom),
                          1'($urandom), $urandom_range(0, 3), d, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
